// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction fetch/issue unit.
//   - instruction class codes (instruction[19:18])
//   - per-class hold lengths in cycles
//   - fetch FSM state encoding
//   - hold_cycles(): class code -> hold length (0 for HALT)
package cpu_pkg;

    localparam logic [1:0] CLS_HALT  = 2'b00;
    localparam logic [1:0] CLS_STD   = 2'b01;
    localparam logic [1:0] CLS_LOAD  = 2'b10;
    localparam logic [1:0] CLS_STORE = 2'b11;

    localparam int HOLD_STD   = 3;  // DECODE, EXECUTE, WRITE_BACK
    localparam int HOLD_LOAD  = 4;  // DECODE, EXECUTE, MEM_ACCESS, WRITE_BACK
    localparam int HOLD_STORE = 3;  // DECODE, EXECUTE, MEM_ACCESS

    // Wide enough for the longest hold plus the extra first-word cycle.
    localparam int CNT_BITS = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    function automatic logic [CNT_BITS-1:0] hold_cycles(input logic [1:0] cls);
        logic [CNT_BITS-1:0] h;
        case (cls)
            CLS_STD:   h = CNT_BITS'(HOLD_STD);
            CLS_LOAD:  h = CNT_BITS'(HOLD_LOAD);
            CLS_STORE: h = CNT_BITS'(HOLD_STORE);
            default:   h = '0;
        endcase
        return h;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bus bundle between the fetch unit and whoever programs/starts it.
//   master: drives prog_we/prog_addr/prog_wdata (program load) and
//           start/start_addr; observes instruction/pc/issue/busy/halted.
//   slave : the fetch unit itself.
interface instr_fetch_if #(
    parameter int INSTR_WIDTH = 20,
    parameter int PC_BITS     = 5
);
    logic                   prog_we;
    logic [PC_BITS-1:0]     prog_addr;
    logic [INSTR_WIDTH-1:0] prog_wdata;
    logic                   start;
    logic [PC_BITS-1:0]     start_addr;
    logic [INSTR_WIDTH-1:0] instruction;
    logic [PC_BITS-1:0]     pc;
    logic                   issue;
    logic                   busy;
    logic                   halted;

    modport master (
        output prog_we, prog_addr, prog_wdata, start, start_addr,
        input  instruction, pc, issue, busy, halted
    );

    modport slave (
        input  prog_we, prog_addr, prog_wdata, start, start_addr,
        output instruction, pc, issue, busy, halted
    );
endinterface

// File: rtl/prog_rom.sv
// Program memory: 2^PC_BITS words of INSTR_WIDTH bits.
//   clk   : write clock
//   we    : write strobe, waddr/wdata written on the rising edge
//   raddr : read address, rdata follows it combinationally
// Contents are deliberately not reset so a program survives rst.
module prog_rom #(
    parameter int INSTR_WIDTH = 20,
    parameter int PC_BITS     = 5
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [PC_BITS-1:0]     waddr,
    input  logic [INSTR_WIDTH-1:0] wdata,
    input  logic [PC_BITS-1:0]     raddr,
    output logic [INSTR_WIDTH-1:0] rdata
);
    localparam int DEPTH = 1 << PC_BITS;

    logic [INSTR_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch/issue unit feeding the CU's 20-bit instruction input.
//   clk : rising-edge clock shared with the CU
//   rst : asynchronous, active-low reset
//   bus : instr_fetch_if.slave
//         in : prog_we/prog_addr/prog_wdata (program load, IDLE/HALT only),
//              start/start_addr (begin execution, IDLE/HALT only)
//         out: instruction (registered word), pc (its address),
//              issue (1-cycle pulse per new word), busy (ISSUE), halted (HALT)
// Each word is held for its class's hold length; the first word after a
// start gets one extra cycle while the CU leaves its own reset state.
// A class-00 word stops the unit in HALT with that word still presented.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int INSTR_WIDTH = 20,
    parameter int PC_BITS     = 5
) (
    input  logic          clk,
    input  logic          rst,
    instr_fetch_if.slave  bus
);
    state_t                 state_reg, state_next;
    logic [PC_BITS-1:0]     pc_reg, pc_next;
    logic [INSTR_WIDTH-1:0] instr_reg, instr_next;
    logic [CNT_BITS-1:0]    cnt_reg, cnt_next;
    logic                   issue_reg, issue_next;

    logic                   rom_we;
    logic [PC_BITS-1:0]     fetch_addr;
    logic [INSTR_WIDTH-1:0] rom_rdata;
    logic [INSTR_WIDTH-1:0] fetch_word;
    logic [1:0]             fetch_cls;
    logic [CNT_BITS-1:0]    fetch_hold;
    logic                   fetch_first;
    logic                   do_fetch;

    // Writes are locked out while a program is running.
    assign rom_we = bus.prog_we && (state_reg != ST_ISSUE);

    // In ISSUE the next word is the sequential one (pc wraps naturally);
    // otherwise it is the start address.
    assign fetch_addr  = (state_reg == ST_ISSUE) ? pc_reg + PC_BITS'(1) : bus.start_addr;
    assign fetch_first = (state_reg != ST_ISSUE);

    prog_rom #(
        .INSTR_WIDTH (INSTR_WIDTH),
        .PC_BITS     (PC_BITS)
    ) u_prog_rom (
        .clk   (clk),
        .we    (rom_we),
        .waddr (bus.prog_addr),
        .wdata (bus.prog_wdata),
        .raddr (fetch_addr),
        .rdata (rom_rdata)
    );

    // A write landing on the address being fetched in the same cycle must
    // win, but the array only updates at the edge, so forward the data.
    assign fetch_word = (rom_we && (bus.prog_addr == fetch_addr)) ? bus.prog_wdata : rom_rdata;
    assign fetch_cls  = fetch_word[INSTR_WIDTH-1 -: 2];
    assign fetch_hold = hold_cycles(fetch_cls);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            pc_reg    <= '0;
            instr_reg <= '0;
            cnt_reg   <= '0;
            issue_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            instr_reg <= instr_next;
            cnt_reg   <= cnt_next;
            issue_reg <= issue_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        instr_next = instr_reg;
        cnt_next   = cnt_reg;
        do_fetch   = 1'b0;

        case (state_reg)
            ST_IDLE, ST_HALT: begin
                do_fetch = bus.start;
            end
            ST_ISSUE: begin
                // Counter at 0 marks the last cycle of the current word.
                if (cnt_reg == '0) begin
                    do_fetch = 1'b1;
                end else begin
                    cnt_next = cnt_reg - CNT_BITS'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (do_fetch) begin
            pc_next    = fetch_addr;
            instr_next = fetch_word;
            if (fetch_cls == CLS_HALT) begin
                state_next = ST_HALT;
                cnt_next   = '0;
            end else begin
                state_next = ST_ISSUE;
                // Loading hold-1 gives exactly hold cycles on the bus; the
                // first word after start keeps the full hold for the extra cycle.
                cnt_next   = fetch_first ? fetch_hold : fetch_hold - CNT_BITS'(1);
            end
        end

        issue_next = do_fetch;
    end

    // Output logic
    always_comb begin
        bus.instruction = instr_reg;
        bus.pc          = pc_reg;
        bus.issue       = issue_reg;
        bus.busy        = (state_reg == ST_ISSUE);
        bus.halted      = (state_reg == ST_HALT);
    end
endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_if #(.INSTR_WIDTH(20), .PC_BITS(5)) bus ();

    instr_fetch #(.INSTR_WIDTH(20), .PC_BITS(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int         cyc;
        logic [4:0] pc;
        logic [19:0] instr;
        logic       halted;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void expect_issue(int c, logic [4:0] p, logic [19:0] i, logic h);
        exp_t e;
        e.cyc = c; e.pc = p; e.instr = i; e.halted = h;
        sb.push_back(e);
    endfunction

    // Scoreboard: every issue pulse is matched against the next expected word.
    exp_t got_e;
    always @(negedge clk) begin
        if (rst && bus.issue === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_issue: cycle %0d pc=%0d instr=%05h, no issue expected",
                         cyc, bus.pc, bus.instruction);
            end else begin
                got_e = sb.pop_front();
                n_checks++;
                if (cyc !== got_e.cyc) $display("FAIL issue_cycle: got cycle %0d want %0d", cyc, got_e.cyc);
                else n_pass++;
                n_checks++;
                if (bus.pc !== got_e.pc) $display("FAIL issue_pc: got %0d want %0d", bus.pc, got_e.pc);
                else n_pass++;
                n_checks++;
                if (bus.instruction !== got_e.instr)
                    $display("FAIL issue_instr: pc %0d got %05h want %05h", got_e.pc, bus.instruction, got_e.instr);
                else n_pass++;
                n_checks++;
                if (bus.halted !== got_e.halted)
                    $display("FAIL issue_halted: pc %0d got %0b want %0b", got_e.pc, bus.halted, got_e.halted);
                else n_pass++;
            end
        end
    end

    task automatic write_word(input logic [4:0] a, input logic [19:0] d);
        @(negedge clk);
        bus.prog_we = 1'b1; bus.prog_addr = a; bus.prog_wdata = d;
        @(negedge clk);
        bus.prog_we = 1'b0;
    endtask

    // Raises start; returns the cycle index at which the first word appears.
    task automatic begin_start(input logic [4:0] a, output int base);
        @(negedge clk);
        base = cyc + 1;
        bus.start = 1'b1; bus.start_addr = a;
    endtask

    task automatic end_start();
        @(negedge clk);
        bus.start = 1'b0; bus.prog_we = 1'b0;
    endtask

    task automatic push_mixed(input int base);
        expect_issue(base,      5'd0, 20'h5B000, 1'b0);
        expect_issue(base + 4,  5'd1, 20'h80050, 1'b0);
        expect_issue(base + 8,  5'd2, 20'hC0030, 1'b0);
        expect_issue(base + 11, 5'd3, 20'h00000, 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.instruction !== 20'h0) $display("FAIL reset_instr: got %05h want 0", bus.instruction); else n_pass++;
        n_checks++; if (bus.pc !== 5'd0) $display("FAIL reset_pc: got %0d want 0", bus.pc); else n_pass++;
        n_checks++; if (bus.issue !== 1'b0) $display("FAIL reset_issue: got %0b want 0", bus.issue); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", bus.busy); else n_pass++;
        n_checks++; if (bus.halted !== 1'b0) $display("FAIL reset_halted: got %0b want 0", bus.halted); else n_pass++;
        rst = 1'b1;
        $display("reset: outputs checked, released");
    endtask

    task automatic test_start_write_same();
        int base;
        write_word(5'd6, 20'h00000);
        begin_start(5'd5, base);
        bus.prog_we = 1'b1; bus.prog_addr = 5'd5; bus.prog_wdata = 20'h5B000;
        expect_issue(base,     5'd5, 20'h5B000, 1'b0);
        expect_issue(base + 4, 5'd6, 20'h00000, 1'b1);
        end_start();
        n_checks++; if (bus.instruction !== 20'h5B000) $display("FAIL same_cycle_instr: got %05h want 5B000", bus.instruction); else n_pass++;
        n_checks++; if (bus.issue !== 1'b1) $display("FAIL same_cycle_issue: got %0b want 1", bus.issue); else n_pass++;
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        n_checks++; if (sb.size() != 0) $display("FAIL same_cycle_drain: %0d issues outstanding, want 0", sb.size()); else n_pass++;
        $display("start+write same cycle: addr 5 fetched from write data");
    endtask

    task automatic test_mixed();
        int base;
        write_word(5'd0, 20'h5B000);
        write_word(5'd1, 20'h80050);
        write_word(5'd2, 20'hC0030);
        write_word(5'd3, 20'h00000);
        begin_start(5'd0, base);
        push_mixed(base);
        end_start();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        n_checks++; if (sb.size() != 0) $display("FAIL mixed_drain: %0d issues outstanding, want 0", sb.size()); else n_pass++;
        n_checks++; if (bus.halted !== 1'b1) $display("FAIL mixed_halted: got %0b want 1", bus.halted); else n_pass++;
        n_checks++; if (bus.pc !== 5'd3) $display("FAIL mixed_pc: got %0d want 3", bus.pc); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL mixed_busy: got %0b want 0", bus.busy); else n_pass++;
        $display("mixed: std/load/store/halt sequence from addr 0");
    endtask

    task automatic test_restart_halt();
        int base;
        begin_start(5'd2, base);
        expect_issue(base,     5'd2, 20'hC0030, 1'b0);
        expect_issue(base + 4, 5'd3, 20'h00000, 1'b1);
        end_start();
        n_checks++; if (bus.halted !== 1'b0) $display("FAIL restart_halted: got %0b want 0", bus.halted); else n_pass++;
        n_checks++; if (bus.busy !== 1'b1) $display("FAIL restart_busy: got %0b want 1", bus.busy); else n_pass++;
        n_checks++; if (bus.pc !== 5'd2) $display("FAIL restart_pc: got %0d want 2", bus.pc); else n_pass++;
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        n_checks++; if (sb.size() != 0) $display("FAIL restart_drain: %0d issues outstanding, want 0", sb.size()); else n_pass++;
        $display("restart from halt: storeR at addr 2 held 4 cycles");
    endtask

    task automatic test_write_while_busy();
        int base;
        begin_start(5'd0, base);
        push_mixed(base);
        end_start();
        bus.prog_we = 1'b1; bus.prog_addr = 5'd1; bus.prog_wdata = 20'hFFFFF;
        @(negedge clk);
        bus.prog_we = 1'b0;
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        n_checks++; if (sb.size() != 0) $display("FAIL busy_write_drain: %0d issues outstanding, want 0", sb.size()); else n_pass++;
        $display("write while busy: addr 1 write ignored");
    endtask

    task automatic test_reset_mid_issue();
        int base;
        begin_start(5'd0, base);
        expect_issue(base,     5'd0, 20'h5B000, 1'b0);
        expect_issue(base + 4, 5'd1, 20'h80050, 1'b0);
        end_start();
        while (cyc < base + 4) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        n_checks++; if (bus.instruction !== 20'h0) $display("FAIL midrst_instr: got %05h want 0", bus.instruction); else n_pass++;
        n_checks++; if (bus.pc !== 5'd0) $display("FAIL midrst_pc: got %0d want 0", bus.pc); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL midrst_busy: got %0b want 0", bus.busy); else n_pass++;
        n_checks++; if (bus.issue !== 1'b0) $display("FAIL midrst_issue: got %0b want 0", bus.issue); else n_pass++;
        n_checks++; if (bus.halted !== 1'b0) $display("FAIL midrst_halted: got %0b want 0", bus.halted); else n_pass++;
        n_checks++; if (sb.size() != 0) $display("FAIL midrst_pending: %0d issues outstanding, want 0", sb.size()); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        begin_start(5'd0, base);
        push_mixed(base);
        end_start();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        n_checks++; if (sb.size() != 0) $display("FAIL midrst_rerun_drain: %0d issues outstanding, want 0", sb.size()); else n_pass++;
        $display("reset mid-issue: outputs cleared, program rerun from memory");
    endtask

    task automatic test_wrap();
        int base;
        write_word(5'd31, 20'h5B000);
        write_word(5'd0,  20'h00000);
        begin_start(5'd31, base);
        expect_issue(base,     5'd31, 20'h5B000, 1'b0);
        expect_issue(base + 4, 5'd0,  20'h00000, 1'b1);
        end_start();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        n_checks++; if (sb.size() != 0) $display("FAIL wrap_drain: %0d issues outstanding, want 0", sb.size()); else n_pass++;
        n_checks++; if (bus.pc !== 5'd0) $display("FAIL wrap_pc: got %0d want 0", bus.pc); else n_pass++;
        n_checks++; if (bus.halted !== 1'b1) $display("FAIL wrap_halted: got %0b want 1", bus.halted); else n_pass++;
        $display("wrap: pc 31 -> 0 then halt");
    endtask

    initial begin
        bus.prog_we    = 1'b0;
        bus.prog_addr  = '0;
        bus.prog_wdata = '0;
        bus.start      = 1'b0;
        bus.start_addr = '0;
        test_reset();
        test_start_write_same();
        test_mixed();
        test_restart_halt();
        test_write_while_busy();
        test_reset_mid_issue();
        test_wrap();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
